// File: rtl/secuencia_programar_pkg.sv
// Shared decoder codes and sequencer state encoding.
package secuencia_programar_pkg;

  localparam logic [4:0] CODE_IDLE  = 5'd0;
  localparam logic [4:0] PROG_FIRST = 5'd1;
  localparam logic [4:0] PROG_LAST  = 5'd21;
  localparam logic [4:0] INIT_FIRST = 5'd22;
  localparam logic [4:0] INIT_LAST  = 5'd29;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_PROG = 2'd1,
    RUN_INIT = 2'd2
  } state_t;

endpackage

// File: rtl/secuencia_programar_step.sv
// Loadable down-counter that times how long each ctrl_W code is held.
module step_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/secuencia_programar.sv
// Sequencer emitting the ctrl_W code stream for the programming decoder.
module secuencia_programar
  import secuencia_programar_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 10,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_prog,
  input  logic       start_init,
  output logic [4:0] ctrl_W,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STEP_CYCLES - 1);

  state_t     state, state_n;
  logic [4:0] code_n;
  logic       busy_n, done_n;
  logic       load, zero;

  step_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (RELOAD),
    .zero     (zero)
  );

  // State and all outputs are registered; no input reaches ctrl_W combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ctrl_W <= CODE_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      ctrl_W <= code_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // Next state, next code and timer reload; done defaults low so it pulses once.
  always_comb begin
    state_n = state;
    code_n  = ctrl_W;
    busy_n  = busy;
    done_n  = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        code_n = CODE_IDLE;
        busy_n = 1'b0;
        if (start_init) begin
          state_n = RUN_INIT;
          code_n  = INIT_FIRST;
          busy_n  = 1'b1;
          load    = 1'b1;
        end else if (start_prog) begin
          state_n = RUN_PROG;
          code_n  = PROG_FIRST;
          busy_n  = 1'b1;
          load    = 1'b1;
        end
      end
      RUN_PROG, RUN_INIT: begin
        if (zero) begin
          if (ctrl_W != ((state == RUN_PROG) ? PROG_LAST : INIT_LAST)) begin
            code_n = ctrl_W + 5'd1;
            load   = 1'b1;
          end else begin
            state_n = IDLE;
            code_n  = CODE_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        code_n  = CODE_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_secuencia_programar.sv
// Self-checking bench: directed sequences, a vector table and a randomized run
// compared against a cycle-count reference model.
module tb_secuencia_programar;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       p4 = 1'b0, i4 = 1'b0, p1 = 1'b0, i1 = 1'b0;
  logic [4:0] c4, c1;
  logic       b4, b1, d4, d1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  secuencia_programar #(.STEP_CYCLES(4), .CNT_W(8)) u4 (
    .clk(clk), .reset(reset), .start_prog(p4), .start_init(i4),
    .ctrl_W(c4), .busy(b4), .done(d4)
  );

  secuencia_programar #(.STEP_CYCLES(1), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .start_prog(p1), .start_init(i1),
    .ctrl_W(c1), .busy(b1), .done(d1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: a run is (first code, length in codes, cycles elapsed).
  int   step_of[2] = '{4, 1};
  int   m_first[2] = '{0, 0};
  int   m_len[2]   = '{0, 0};
  int   m_k[2]     = '{0, 0};
  logic m_done[2]  = '{1'b0, 1'b0};

  always @(posedge clk or negedge reset) begin
    logic sp, si;
    for (int d = 0; d < 2; d++) begin
      sp = (d == 0) ? p4 : p1;
      si = (d == 0) ? i4 : i1;
      if (!reset) begin
        m_len[d] = 0; m_k[d] = 0; m_done[d] = 1'b0;
      end else if (m_len[d] == 0) begin
        m_done[d] = 1'b0;
        if (si) begin
          m_first[d] = 22; m_len[d] = 8; m_k[d] = 1;
        end else if (sp) begin
          m_first[d] = 1; m_len[d] = 21; m_k[d] = 1;
        end
      end else begin
        m_k[d]++;
        if (m_k[d] > m_len[d] * step_of[d]) begin
          m_len[d] = 0; m_done[d] = 1'b1;
        end
      end
    end
  end

  function automatic int m_code(input int d);
    return (m_len[d] == 0) ? 0 : m_first[d] + (m_k[d] - 1) / step_of[d];
  endfunction

  always @(negedge clk) begin
    chk("model_code4", c4, m_code(0));
    chk("model_busy4", b4, (m_len[0] != 0) ? 1 : 0);
    chk("model_done4", d4, m_done[0]);
    chk("model_code1", c1, m_code(1));
    chk("model_busy1", b1, (m_len[1] != 0) ? 1 : 0);
    chk("model_done1", d1, m_done[1]);
  end

  typedef struct {
    logic       sp;
    logic       si;
    logic [4:0] code;
    logic       bsy;
    logic       dn;
  } vec_t;

  vec_t tbl[12];
  int   ndone;
  bit   found;

  initial begin
    // STEP_CYCLES=1 table: INIT run, restart PROG on the done edge, busy ignores start.
    tbl[0] = '{1'b0, 1'b1, 5'd22, 1'b1, 1'b0};
    for (int k = 1; k <= 7; k++) tbl[k] = '{1'b0, 1'b0, 5'(22 + k), 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 5'd1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 5'd2, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 5'd3, 1'b1, 1'b0};

    repeat (2) tick();
    chk("rst_code", c4, 0);
    chk("rst_busy", b4, 0);
    chk("rst_done", d4, 0);
    reset = 1'b1;
    tick();

    // PROG run, STEP_CYCLES=4.
    p4 = 1'b1; tick(); p4 = 1'b0;
    for (int cyc = 1; cyc <= 85; cyc++) begin
      chk("prog_code", c4, (cyc <= 84) ? (cyc - 1) / 4 + 1 : 0);
      chk("prog_busy", b4, (cyc <= 84) ? 1 : 0);
      chk("prog_done", d4, (cyc == 85) ? 1 : 0);
      tick();
    end
    chk("prog_idle", c4, 0);

    // PROG run with a redundant start mid-run: exactly one done, same length.
    p4 = 1'b1; tick(); p4 = 1'b0;
    ndone = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc == 10) p4 = 1'b1;
      if (cyc == 11) p4 = 1'b0;
      if (cyc == 84) chk("rerun_last", c4, 21);
      if (cyc == 85) chk("rerun_end", d4, 1);
      if (d4) ndone++;
      tick();
    end
    chk("rerun_ndone", ndone, 1);

    // Both starts together: INIT wins, PROG dropped.
    p4 = 1'b1; i4 = 1'b1; tick(); p4 = 1'b0; i4 = 1'b0;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      chk("init_code", c4, (cyc <= 32) ? 22 + (cyc - 1) / 4 : 0);
      chk("init_done", d4, (cyc == 33) ? 1 : 0);
      tick();
    end
    ndone = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (b4 || d4) ndone++;
      tick();
    end
    chk("init_no_prog", ndone, 0);

    // Asynchronous reset while ctrl_W=7.
    p4 = 1'b1; tick(); p4 = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      if (c4 == 5'd7) found = 1'b1;
      else tick();
    end
    chk("reach_code7", found, 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_code", c4, 0);
    chk("arst_busy", b4, 0);
    chk("arst_done", d4, 0);
    tick(); tick();
    reset = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      chk("post_rst_idle", {27'd0, b4, c4}, 0);
    end

    // Vector table on the STEP_CYCLES=1 instance.
    foreach (tbl[i]) begin
      p1 = tbl[i].sp; i1 = tbl[i].si;
      tick();
      chk("tbl_code", c1, tbl[i].code);
      chk("tbl_busy", b1, tbl[i].bsy);
      chk("tbl_done", d1, tbl[i].dn);
    end
    p1 = 1'b0; i1 = 1'b0;
    repeat (25) tick();

    // STEP_CYCLES=1 with start_prog held: back-to-back runs.
    p1 = 1'b1; tick();
    for (int k = 1; k <= 21; k++) begin
      chk("held_code", c1, k);
      tick();
    end
    chk("held_zero", c1, 0);
    chk("held_done", d1, 1);
    tick();
    chk("held_restart", c1, 1);
    chk("held_done_drop", d1, 0);
    p1 = 1'b0;
    repeat (25) tick();

    // Randomized starts and occasional async resets against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      p4 = ($urandom_range(0, 29) == 0);
      i4 = ($urandom_range(0, 59) == 0);
      p1 = ($urandom_range(0, 9) == 0);
      i1 = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      tick();
    end
    p4 = 1'b0; i4 = 1'b0; p1 = 1'b0; i1 = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/secuencia_programar.md
Name: secuencia_programar

Overview:
- Sequencer directly upstream of the programming decoder.
- Generates the 5-bit ctrl_W code stream the decoder turns into RTC bus strobes (Op_W, I_W, AD_W, Addr_W, sel_prog, data_sel, Fin_W, Inicio_E).
- Runs two fixed sequences, each code held for a programmable number of clocks:
  - write/program: codes 1..21 (b..v)
  - RTC init: codes 22..29 (w..D)
- Reports busy and a done pulse to the top-level controller.

Parameters:
- STEP_CYCLES, 10: clocks each ctrl_W code is held; legal range 1..255.
- CNT_W, 8: step-counter width; must satisfy 2^CNT_W > STEP_CYCLES-1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start_prog  in  1  request program sequence; sampled each edge, level or pulse
- start_init  in  1  request init sequence; sampled each edge, level or pulse
- ctrl_W  out  5  code to programming decoder
- busy  out  1  high while a sequence runs
- done  out  1  one-cycle pulse when a sequence completes

Behaviour:
- Reset (reset=0, asynchronous): ctrl_W=0, busy=0, done=0, step counter=0, FSM=IDLE. Takes effect immediately, including mid-sequence.
- IDLE:
  - ctrl_W=0, busy=0.
  - On an edge with start_init=1: ctrl_W<=22, cnt<=STEP_CYCLES-1, go to RUN_INIT, busy<=1.
  - Otherwise, on an edge with start_prog=1: ctrl_W<=1, cnt<=STEP_CYCLES-1, go to RUN_PROG, busy<=1.
  - Both asserted together: init wins; the prog request is dropped, not queued.
- RUN_PROG / RUN_INIT, each edge:
  - cnt>0: cnt<=cnt-1, ctrl_W unchanged.
  - cnt==0 and ctrl_W < last code (21 for PROG, 29 for INIT): ctrl_W<=ctrl_W+1, cnt<=STEP_CYCLES-1.
  - cnt==0 and ctrl_W == last code: ctrl_W<=0, busy<=0, done<=1, go to IDLE.
- Each code is held for exactly STEP_CYCLES cycles. Codes increment by 1 and never skip.
- Sequence lengths:
  - PROG = 21*STEP_CYCLES cycles of busy.
  - INIT = 8*STEP_CYCLES cycles of busy.
- done:
  - High for exactly the one cycle in which ctrl_W has returned to 0.
  - Cleared at the next edge.
  - done and a new start sampled on that same edge: the new sequence starts; done still drops.
- start_prog / start_init while busy: ignored and not queued.
- STEP_CYCLES=1: code advances every clock; no dead cycles.
- Codes 30, 31 and 0 outside IDLE are never emitted. ctrl_W is a registered output only, with no combinational path from inputs.
- No wrap-around: the counter only counts down from STEP_CYCLES-1 to 0.

Decomposition:
- Shared package: localparams for decoder codes used by the sequencer and by the decoder testbench:
  - CODE_IDLE=0
  - PROG_FIRST=1, PROG_LAST=21
  - INIT_FIRST=22, INIT_LAST=29
  - FSM state encoding IDLE / RUN_PROG / RUN_INIT
- One natural sub-module: step_timer.
  - Loadable down-counter, CNT_W wide.
  - Inputs: load, load_val.
  - Output: zero flag.
  - Instantiated once.

Test Plan:
- STEP_CYCLES=4, reset released, start_prog pulsed at edge 0:
  - ctrl_W=1 cycles 1-4, =2 cycles 5-8, …, =21 cycles 81-84.
  - ctrl_W=0 with done=1 at cycle 85; busy high cycles 1-84.
- STEP_CYCLES=4, start_init pulsed:
  - ctrl_W steps 22..29, each held 4 cycles (32 busy cycles).
  - Returns to 0 with a single done pulse.
- start_prog and start_init asserted on the same edge:
  - ctrl_W=22 next cycle; INIT runs; no PROG run follows.
- start_prog pulsed at cycle 10 during an active PROG run:
  - Sequence timing unchanged; exactly one done.
- reset driven low asynchronously mid-run while ctrl_W=7:
  - ctrl_W=0, busy=0, done=0 immediately, with no clock needed.
  - After reset release, IDLE is held until a start arrives.
- STEP_CYCLES=1, start_prog held high continuously:
  - ctrl_W=1..21 on consecutive cycles, 0 with done for one cycle.
  - ctrl_W=1 again on the following cycle.
